multicycle_mem_responder: RTL

MULTICYCLE_MEM_RESPONDER -- requirements
Module: multicycle_mem_responder

---
 rtl/multicycle_mem_responder_pkg.sv | 35 +++
 rtl/multicycle_mem_responder_mem_array.sv | 42 ++++
 rtl/multicycle_mem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/multicycle_mem_responder_pkg.sv
// Shared types and widths for the multi-cycle memory responder: FSM states,
// access opcode, latched request payload and counter/bus widths.
package multicycle_mem_responder_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned BE_W          = DATA_W / 8;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned DEFAULT_DEPTH = 256;
    localparam int unsigned DEFAULT_IDX_W = $clog2(DEFAULT_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    // Word-index width for a power-of-two depth.
    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/multicycle_mem_responder_mem_array.sv
// Word storage with synchronous byte-enabled write and a registered read port.
// The array itself has no reset; only the read register clears.
module mem_array
    import multicycle_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned IDX_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is only non-zero for the single cycle following a read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/multicycle_mem_responder.sv
// Fixed-latency memory responder: accepts one request in IDLE, waits LATENCY
// cycles, performs the array access on the edge into RESP and pulses ready.
module multicycle_mem_responder
    import multicycle_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IDX_W = idx_width(DEPTH);

    state_e           state;
    state_e           next_state;
    logic [CNT_W-1:0] cnt;
    mem_req_t         req_q;
    mem_req_t         in_req;
    mem_req_t         cur;
    logic             enter_resp;
    logic             aligned;
    logic             wr_en;
    logic             rd_en;
    logic             ready_d;
    logic             busy_d;
    logic             err_d;
    logic             unused_addr_hi;

    always_comb begin
        in_req       = '0;
        in_req.op    = we ? OP_WRITE : OP_READ;
        in_req.addr  = addr;
        in_req.wdata = wdata;
        in_req.be    = be;
    end

    // With LATENCY=1 the access happens on the accept edge, so use live inputs.
    assign cur            = (state == ST_IDLE) ? in_req : req_q;
    assign aligned        = (cur.addr[1:0] == 2'b00);
    assign unused_addr_hi = ^cur.addr[ADDR_W-1:IDX_W+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req) next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == CNT_W'(1)) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        enter_resp = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        enter_resp = (next_state == ST_RESP) && (state != ST_RESP);
        wr_en      = enter_resp && aligned && (cur.op == OP_WRITE);
        rd_en      = enter_resp && aligned && (cur.op == OP_READ);
        ready_d    = enter_resp;
        busy_d     = (next_state != ST_IDLE);
        err_d      = enter_resp && !aligned;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= ready_d;
            busy  <= busy_d;
            err   <= err_d;
        end
    end

    // Request latch and latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            req_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        cnt   <= CNT_W'(LATENCY - 1);
                        req_q <= in_req;
                    end
                end
                ST_WAIT: cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .idx   (cur.addr[IDX_W+1:2]),
        .wdata (cur.wdata),
        .be    (cur.be),
        .rdata (rdata)
    );

endmodule
